// File: rtl/clock_hms_alarm.sv
// Parametrised h:m:s up/down counter with range-checked load, wrap carry and latched alarm.
// Optional alarm logic is built only when CLOCK_HMS_ALARM_ALARM_EN is defined.
module clock_hms_alarm #(
  parameter int W        = 6,
  parameter int MAX_H    = 24,
  parameter int MAX_M    = 60,
  parameter int MAX_S    = 60,
  parameter int INIT_H   = 0,
  parameter int INIT_M   = 0,
  parameter int INIT_S   = 0,
  parameter int RING_LEN = 30
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         set,
  input  logic [W-1:0] set_h,
  input  logic [W-1:0] set_m,
  input  logic [W-1:0] set_s,
  output logic [W-1:0] out_h,
  output logic [W-1:0] out_m,
  output logic [W-1:0] out_s,
  output logic         carry,
  input  logic         alarm_wr,
  input  logic [W-1:0] alarm_h,
  input  logic [W-1:0] alarm_m,
  input  logic         alarm_ack,
  output logic         alarm_ring
);

  typedef enum logic {WORK, HOLD} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] h_q, h_d, m_q, m_d, s_q, s_d;
  logic         carry_q, carry_d;
  logic         step;

  function automatic logic [W-1:0] clamp(input logic [W-1:0] v, input int lim);
    return (32'(v) >= lim) ? '0 : v;
  endfunction

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    m_d     = m_q;
    s_d     = s_q;
    carry_d = 1'b0;
    step    = 1'b0;
    if (set) begin
      h_d     = clamp(set_h, MAX_H);
      m_d     = clamp(set_m, MAX_M);
      s_d     = clamp(set_s, MAX_S);
      state_d = HOLD;
    end else if (state_q == HOLD) begin
      state_d = WORK;
    end else if (en) begin
      step = 1'b1;
      if (!dir) begin
        if (s_q == W'(MAX_S-1)) begin
          s_d = '0;
          if (m_q == W'(MAX_M-1)) begin
            m_d = '0;
            if (h_q == W'(MAX_H-1)) begin
              h_d     = '0;
              carry_d = 1'b1;
            end else begin
              h_d = h_q + W'(1);
            end
          end else begin
            m_d = m_q + W'(1);
          end
        end else begin
          s_d = s_q + W'(1);
        end
      end else begin
        if (s_q == '0) begin
          s_d = W'(MAX_S-1);
          if (m_q == '0) begin
            m_d = W'(MAX_M-1);
            if (h_q == '0) begin
              h_d     = W'(MAX_H-1);
              carry_d = 1'b1;
            end else begin
              h_d = h_q - W'(1);
            end
          end else begin
            m_d = m_q - W'(1);
          end
        end else begin
          s_d = s_q - W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WORK;
      h_q     <= W'(INIT_H);
      m_q     <= W'(INIT_M);
      s_q     <= W'(INIT_S);
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      s_q     <= s_d;
      carry_q <= carry_d;
    end
  end

  assign out_h = h_q;
  assign out_m = m_q;
  assign out_s = s_q;
  assign carry = carry_q;

`ifdef CLOCK_HMS_ALARM_ALARM_EN
  localparam int CW = $clog2(RING_LEN + 1);

  logic [W-1:0]  ah_q, ah_d, am_q, am_d;
  logic          armed_q, armed_d, ring_q, ring_d;
  logic [CW-1:0] rc_q, rc_d;

  // Match uses the pre-edge alarm registers; a new match outranks a same-cycle ack.
  always_comb begin
    ah_d    = ah_q;
    am_d    = am_q;
    armed_d = armed_q;
    ring_d  = ring_q;
    rc_d    = rc_q;
    if (alarm_wr) begin
      ah_d    = clamp(alarm_h, MAX_H);
      am_d    = clamp(alarm_m, MAX_M);
      armed_d = 1'b1;
    end
    if (set) begin
      ring_d = 1'b0;
      rc_d   = '0;
    end else if (step && armed_q && h_d == ah_q && m_d == am_q && s_d == '0) begin
      ring_d = 1'b1;
      rc_d   = CW'(RING_LEN);
    end else if (alarm_ack) begin
      ring_d = 1'b0;
      rc_d   = '0;
    end else if (step && ring_q) begin
      if (rc_q <= CW'(1)) begin
        ring_d = 1'b0;
        rc_d   = '0;
      end else begin
        rc_d = rc_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ah_q    <= '0;
      am_q    <= '0;
      armed_q <= 1'b0;
      ring_q  <= 1'b0;
      rc_q    <= '0;
    end else begin
      ah_q    <= ah_d;
      am_q    <= am_d;
      armed_q <= armed_d;
      ring_q  <= ring_d;
      rc_q    <= rc_d;
    end
  end

  assign alarm_ring = ring_q;
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{alarm_wr, alarm_h, alarm_m, alarm_ack};
  assign alarm_ring = 1'b0;
`endif

endmodule

// File: tb/tb_clock_hms_alarm.sv
// Self-checking bench for clock_hms_alarm: directed scenarios then random traffic,
// compared against a total-seconds reference model.
module tb_clock_hms_alarm;
  localparam int W = 6, MH = 24, MM = 60, MS = 60, RL = 30;
  localparam int NT = MH * MM * MS;
`ifdef CLOCK_HMS_ALARM_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, en, dir, set, alarm_wr, alarm_ack;
  logic [W-1:0] set_h, set_m, set_s, alarm_h, alarm_m;
  logic [W-1:0] out_h, out_m, out_s;
  logic carry, alarm_ring;

  int checks = 0;
  int errors = 0;

  // reference model state
  int t, at, rc;
  bit hold, armed, ring, carry_e;

  always #5 clk = ~clk;

  clock_hms_alarm #(.W(W), .MAX_H(MH), .MAX_M(MM), .MAX_S(MS), .RING_LEN(RL)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .set(set),
    .set_h(set_h), .set_m(set_m), .set_s(set_s),
    .out_h(out_h), .out_m(out_m), .out_s(out_s), .carry(carry),
    .alarm_wr(alarm_wr), .alarm_h(alarm_h), .alarm_m(alarm_m),
    .alarm_ack(alarm_ack), .alarm_ring(alarm_ring)
  );

  function automatic int lim(input int v, input int m);
    return (v >= m) ? 0 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    assert (got === 32'(exp))
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit counted;
    int old_at;
    bit old_armed;
    @(posedge clk);
    if (reset) begin
      t = 0; hold = 0; carry_e = 0; ring = 0; armed = 0; at = 0; rc = 0;
    end else begin
      counted = 0;
      carry_e = 0;
      if (set) begin
        t = lim(set_h, MH) * MM * MS + lim(set_m, MM) * MS + lim(set_s, MS);
        hold = 1;
      end else if (hold) begin
        hold = 0;
      end else if (en) begin
        counted = 1;
        if (!dir) begin
          t = (t + 1) % NT;
          carry_e = (t == 0);
        end else begin
          carry_e = (t == 0);
          t = (t + NT - 1) % NT;
        end
      end
      old_at = at;
      old_armed = armed;
      if (alarm_wr) begin
        at = (lim(alarm_h, MH) * MM + lim(alarm_m, MM)) * MS;
        armed = 1;
      end
      if (set) ring = 0;
      else if (counted && old_armed && t == old_at) begin ring = 1; rc = RL; end
      else if (alarm_ack) ring = 0;
      else if (counted && ring) begin
        rc--;
        if (rc == 0) ring = 0;
      end
    end
    #1;
    chk("out_h", 32'(out_h), t / (MM * MS));
    chk("out_m", 32'(out_m), (t / MS) % MM);
    chk("out_s", 32'(out_s), t % MS);
    chk("carry", 32'(carry), int'(carry_e));
    chk("alarm_ring", 32'(alarm_ring), int'(ring & ALARM));
    @(negedge clk);
  endtask

  task automatic load(input int h, input int m, input int s);
    set = 1; set_h = W'(h); set_m = W'(m); set_s = W'(s);
    tick();
    set = 0;
  endtask

  task automatic wr_alarm(input int h, input int m);
    alarm_wr = 1; alarm_h = W'(h); alarm_m = W'(m);
    tick();
    alarm_wr = 0;
  endtask

  initial begin
    reset = 1; en = 0; dir = 0; set = 0; alarm_wr = 0; alarm_ack = 0;
    set_h = '0; set_m = '0; set_s = '0; alarm_h = '0; alarm_m = '0;
    t = 0; at = 0; rc = 0; hold = 0; armed = 0; ring = 0; carry_e = 0;
    @(negedge clk);
    tick();
    reset = 0;
    tick();

    // up wrap: load with en high, HOLD cycle, then wrap with carry
    en = 1; dir = 0;
    load(23, 59, 58);
    repeat (4) tick();

    // down wrap
    dir = 1;
    load(0, 0, 1);
    repeat (4) tick();
    dir = 0;

    // out-of-range load with en high
    load(25, 61, 30);
    repeat (3) tick();

    // alarm ring then ack five ticks later
    wr_alarm(7, 30);
    load(7, 29, 58);
    repeat (3) tick();
    repeat (5) tick();
    alarm_ack = 1;
    tick();
    alarm_ack = 0;
    repeat (2) tick();

    // timeout, then set landing on alarm time, then out-of-range alarm write
    load(7, 29, 58);
    repeat (35) tick();
    load(7, 30, 0);
    repeat (3) tick();
    wr_alarm(40, 70);
    load(23, 59, 59);
    repeat (3) tick();

    // ack and match in the same cycle: match restarts the ring
    wr_alarm(7, 30);
    load(7, 29, 58);
    repeat (2) tick();
    alarm_ack = 1;
    tick();
    alarm_ack = 0;
    repeat (31) tick();

    // down-count match, dir toggle, and reset mid-ring
    dir = 1;
    load(7, 30, 2);
    repeat (4) tick();
    dir = 0;
    wr_alarm(12, 0);
    load(11, 59, 58);
    repeat (8) tick();
    reset = 1;
    tick();
    reset = 0; en = 0;
    repeat (3) tick();
    en = 1;
    repeat (2) tick();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      reset     = ($urandom_range(0, 599) == 0);
      set       = ($urandom_range(0, 49) == 0);
      set_h     = W'($urandom_range(0, 63));
      set_m     = W'($urandom_range(0, 63));
      set_s     = W'($urandom_range(0, 63));
      alarm_ack = ($urandom_range(0, 19) == 0);
      alarm_wr  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) begin
        alarm_h = W'($urandom_range(0, 63));
        alarm_m = W'($urandom_range(0, 63));
      end else begin
        alarm_h = W'((t / (MM * MS) + ((t / MS) % MM == MM - 1 ? 1 : 0)) % MH);
        alarm_m = W'(((t / MS) % MM + 1) % MM);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
